// File: rtl/wb_gcd_pkg.sv
// Shared definitions for the Wishbone GCD initiator: responder register map,
// control/status bit positions and the sequencer state encoding.
package wb_gcd_pkg;

  localparam logic [31:0] OFS_A      = 32'h0000_0000;
  localparam logic [31:0] OFS_B      = 32'h0000_0004;
  localparam logic [31:0] OFS_CTRL   = 32'h0000_0008;
  localparam logic [31:0] OFS_STATUS = 32'h0000_000C;
  localparam logic [31:0] OFS_RESULT = 32'h0000_0010;

  localparam int unsigned CTRL_GO     = 0;
  localparam int unsigned STATUS_DONE = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_A    = 3'd1,
    WR_B    = 3'd2,
    WR_GO   = 3'd3,
    RD_STAT = 3'd4,
    GAP     = 3'd5,
    RD_RES  = 3'd6,
    RESP    = 3'd7
  } state_t;

endpackage

// File: rtl/wb_single_xfer.sv
// Registered Wishbone classic single-transfer engine. A start pulse loads one
// transfer; a start coinciding with the acking edge chains a back-to-back transfer.
module wb_single_xfer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        start_we,
  input  logic [31:0] start_adr,
  input  logic [31:0] start_dat,
  input  logic        ack,
  input  logic [31:0] bus_rdata,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [3:0]  sel,
  output logic [31:0] adr,
  output logic [31:0] dat,
  output logic        done,
  output logic [31:0] rdata
);

  // ack is only meaningful while a strobe is outstanding
  assign done  = stb & ack;
  assign rdata = bus_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= 1'b0;
      stb <= 1'b0;
      we  <= 1'b0;
      sel <= '0;
      adr <= '0;
      dat <= '0;
    end else if (start) begin
      cyc <= 1'b1;
      stb <= 1'b1;
      we  <= start_we;
      sel <= '1;
      adr <= start_adr;
      dat <= start_dat;
    end else if (done) begin
      cyc <= 1'b0;
      stb <= 1'b0;
      we  <= 1'b0;
      sel <= '0;
    end
  end

endmodule

// File: rtl/wb_gcd_master.sv
// Wishbone classic initiator running one GCD job on a memory-mapped responder.
// Optional poll timeout is compiled in with `define WB_GCD_MASTER_TIMEOUT_EN.
module wb_gcd_master
  import wb_gcd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_gcd_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [15:0] GAP_LAST = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : '0;

  state_t      state, state_next;
  logic [31:0] b_q;
  logic [15:0] gap_cnt;
  logic [31:0] rsp_gcd;
  logic        expired;

  logic        start, start_we, done;
  logic [31:0] start_adr, start_dat, rdata;

  wb_single_xfer u_xfer (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .start     (start),
    .start_we  (start_we),
    .start_adr (start_adr),
    .start_dat (start_dat),
    .ack       (wbm_ack_i),
    .bus_rdata (wbm_dat_i),
    .cyc       (wbm_cyc_o),
    .stb       (wbm_stb_o),
    .we        (wbm_we_o),
    .sel       (wbm_sel_o),
    .adr       (wbm_adr_o),
    .dat       (wbm_dat_o),
    .done      (done),
    .rdata     (rdata)
  );

  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_we   = 1'b0;
    start_adr  = BASE_ADDR;
    start_dat  = '0;
    case (state)
      // A goes straight into the transfer register at accept; only B needs holding
      IDLE: if (cmd_valid_i) begin
        state_next = WR_A;
        start      = 1'b1;
        start_we   = 1'b1;
        start_adr  = BASE_ADDR + OFS_A;
        start_dat  = cmd_a_i;
      end
      WR_A: if (done) begin
        state_next = WR_B;
        start      = 1'b1;
        start_we   = 1'b1;
        start_adr  = BASE_ADDR + OFS_B;
        start_dat  = b_q;
      end
      WR_B: if (done) begin
        state_next = WR_GO;
        start      = 1'b1;
        start_we   = 1'b1;
        start_adr  = BASE_ADDR + OFS_CTRL;
        start_dat  = 32'd1 << CTRL_GO;
      end
      WR_GO: if (done) begin
        state_next = RD_STAT;
        start      = 1'b1;
        start_adr  = BASE_ADDR + OFS_STATUS;
      end
      RD_STAT: if (done) begin
        if (expired) begin
          state_next = RESP;
        end else if (rdata[STATUS_DONE]) begin
          state_next = RD_RES;
          start      = 1'b1;
          start_adr  = BASE_ADDR + OFS_RESULT;
        end else if (POLL_GAP == 0) begin
          start      = 1'b1;
          start_adr  = BASE_ADDR + OFS_STATUS;
        end else begin
          state_next = GAP;
        end
      end
      GAP: if (expired) begin
        state_next = RESP;
      end else if (gap_cnt == GAP_LAST) begin
        state_next = RD_STAT;
        start      = 1'b1;
        start_adr  = BASE_ADDR + OFS_STATUS;
      end
      RD_RES: if (done) state_next = RESP;
      RESP:   if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      b_q     <= '0;
      gap_cnt <= '0;
      rsp_gcd <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : '0;
      if (state == IDLE && cmd_valid_i) b_q <= cmd_b_i;
      if (state == RD_RES && done) rsp_gcd <= rdata;
      else if (state != RESP && state_next == RESP) rsp_gcd <= '0;
    end
  end

`ifdef WB_GCD_MASTER_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        err;

  assign expired = (tcnt >= 32'(TIMEOUT));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      // clearing while in WR_GO equals clearing on entry to the first status read
      if (state == WR_GO) tcnt <= '0;
      else if ((state == RD_STAT || state == GAP) && !expired) tcnt <= tcnt + 32'd1;
      if (state == RD_RES && done) err <= 1'b0;
      else if (state != RESP && state_next == RESP) err <= 1'b1;
    end
  end

  assign rsp_err_o = err;
`else
  assign expired   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  assign cmd_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign rsp_gcd_o   = rsp_gcd;

endmodule

// File: tb/tb_wb_gcd_master.sv
// Self-checking bench for wb_gcd_master with a behavioural GCD responder and a
// result scoreboard; covers WB_GCD_MASTER_TIMEOUT_EN when that macro is defined.
module tb_wb_gcd_master;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_gcd;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_gcd_master #(.BASE_ADDR(BASE), .POLL_GAP(4), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_gcd_o(rsp_gcd), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          stamp;
  } xfer_t;

  xfer_t       bus_log[$];
  logic [31:0] exp_q[$];

  int          cyc_n = 0, wcnt = 0, polls = 0, stab_err = 0;
  int          wait_n = 0, notdone_n = 0;
  bit          never_done = 1'b0;
  logic [31:0] reg_a = '0, reg_b = '0, reg_res = '0;
  logic [31:0] hold_adr = '0, hold_dat = '0;
  logic        hold_we = 1'b0;

  function automatic logic [31:0] gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q, t;
    p = x; q = y;
    while (q != 0) begin
      t = p % q; p = q; q = t;
    end
    return p;
  endfunction

  // responder: combinational ack after wait_n wait states
  always_comb begin
    ack   = stb && (wcnt >= wait_n);
    dat_i = '0;
    if (adr == BASE + 32'h0C) dat_i = {31'b0, (!never_done && polls >= notdone_n)};
    else if (adr == BASE + 32'h10) dat_i = reg_res;
  end

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (rst) begin
      wcnt <= 0;
    end else if (stb) begin
      if (wcnt == 0) begin
        hold_adr <= adr; hold_dat <= dat_o; hold_we <= we;
      end else if (adr !== hold_adr || dat_o !== hold_dat || we !== hold_we || sel !== 4'hF) begin
        stab_err <= stab_err + 1;
      end
      if (ack) begin
        wcnt <= 0;
        bus_log.push_back('{we, adr, (we ? dat_o : dat_i), cyc_n});
        if (we && adr == BASE)         reg_a <= dat_o;
        if (we && adr == BASE + 32'h4) reg_b <= dat_o;
        if (we && adr == BASE + 32'h8) begin
          reg_res <= gcd(reg_a, reg_b);
          polls   <= 0;
        end
        if (!we && adr == BASE + 32'hC) polls <= polls + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int idle, output bit timed_out);
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; idle = 0;
    while (!rsp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (!cyc && !rsp_valid) idle++;
    end
    timed_out = !rsp_valid;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({cyc, stb, we, sel, adr, dat_o, rsp_valid, rsp_err, rsp_gcd} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h v=%b e=%b g=%h want all 0",
               cyc, stb, we, sel, adr, dat_o, rsp_valid, rsp_err, rsp_gcd);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e_adr[5], e_dat[5], want;
    logic        e_we[5];
    int lat, idle, st;
    bit to;
    e_adr = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'h10};
    e_dat = '{32'd48, 32'd18, 32'd1, 32'd1, 32'd6};
    e_we  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    st = bus_log.size();
    exp_q.push_back(gcd(48, 18));
    run_job(48, 18, lat, idle, to);
    compared++;
    if (to || lat != 5) begin
      mismatched++;
      $display("FAIL basic_latency: got %0d (timeout=%0b) want 5", lat, to);
    end
    compared++;
    if (bus_log.size() != st + 5) begin
      mismatched++;
      $display("FAIL basic_xfer_count: got %0d want 5", bus_log.size() - st);
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        compared++;
        if (bus_log[st+i].we !== e_we[i] || bus_log[st+i].adr !== e_adr[i] || bus_log[st+i].dat !== e_dat[i]) begin
          mismatched++;
          $display("FAIL basic_xfer%0d: got we=%b adr=%h dat=%0d want we=%b adr=%h dat=%0d", i,
                   bus_log[st+i].we, bus_log[st+i].adr, bus_log[st+i].dat, e_we[i], e_adr[i], e_dat[i]);
        end
      end
    end
    want = exp_q.pop_front();
    compared++;
    if (rsp_gcd !== want || rsp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_result: got gcd=%0d err=%b want gcd=%0d err=0", rsp_gcd, rsp_err, want);
    end
    handshake();
    compared++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_after_hs: got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_wait_states();
    int lat, idle, st;
    bit to;
    logic [31:0] want;
    wait_n = 3;
    st = stab_err;
    exp_q.push_back(gcd(1071, 462));
    run_job(1071, 462, lat, idle, to);
    want = exp_q.pop_front();
    compared++;
    if (to || lat != 20) begin
      mismatched++;
      $display("FAIL wait_latency: got %0d (timeout=%0b) want 20", lat, to);
    end
    compared++;
    if (rsp_gcd !== want || rsp_err !== 1'b0) begin
      mismatched++;
      $display("FAIL wait_result: got gcd=%0d err=%b want gcd=%0d err=0", rsp_gcd, rsp_err, want);
    end
    compared++;
    if (stab_err != st) begin
      mismatched++;
      $display("FAIL wait_stability: got %0d unstable cycles want 0", stab_err - st);
    end
    handshake();
    wait_n = 0;
  endtask

  task automatic test_polling();
    int lat, idle, st, nstat, last_stamp, bad_gap;
    bit to;
    logic [31:0] want;
    notdone_n = 3;
    st = bus_log.size();
    exp_q.push_back(gcd(96, 60));
    run_job(96, 60, lat, idle, to);
    want = exp_q.pop_front();
    nstat = 0; bad_gap = 0; last_stamp = -1;
    for (int i = st; i < bus_log.size(); i++) begin
      if (!bus_log[i].we && bus_log[i].adr == BASE + 32'hC) begin
        if (last_stamp >= 0 && bus_log[i].stamp - last_stamp != 5) bad_gap++;
        last_stamp = bus_log[i].stamp;
        nstat++;
      end
    end
    compared++;
    if (nstat != 4) begin
      mismatched++;
      $display("FAIL poll_count: got %0d status reads want 4", nstat);
    end
    compared++;
    if (bad_gap != 0 || idle != 12) begin
      mismatched++;
      $display("FAIL poll_gap: got %0d bad spacings, %0d idle cycles want 0, 12", bad_gap, idle);
    end
    compared++;
    if (to || lat != 20) begin
      mismatched++;
      $display("FAIL poll_latency: got %0d (timeout=%0b) want 20", lat, to);
    end
    compared++;
    if (bus_log.size() == 0 || bus_log[bus_log.size()-1].adr !== BASE + 32'h10 || rsp_gcd !== want) begin
      mismatched++;
      $display("FAIL poll_result: got gcd=%0d want %0d after RESULT read", rsp_gcd, want);
    end
    handshake();
    notdone_n = 0;
  endtask

  task automatic test_timeout();
    int lat, idle, st, nres, nstat;
    bit to;
`ifdef WB_GCD_MASTER_TIMEOUT_EN
    never_done = 1'b1;
    st = bus_log.size();
    run_job(9, 6, lat, idle, to);
    nres = 0; nstat = 0;
    for (int i = st; i < bus_log.size(); i++) begin
      if (bus_log[i].adr == BASE + 32'h10) nres++;
      if (bus_log[i].adr == BASE + 32'hC) nstat++;
    end
    compared++;
    if (to || rsp_err !== 1'b1 || rsp_gcd !== 32'd0) begin
      mismatched++;
      $display("FAIL timeout_rsp: got timeout=%0b err=%b gcd=%0d want response err=1 gcd=0", to, rsp_err, rsp_gcd);
    end
    compared++;
    if (nres != 0 || nstat == 0) begin
      mismatched++;
      $display("FAIL timeout_bus: got %0d result reads, %0d status reads want 0, >0", nres, nstat);
    end
    handshake();
    never_done = 1'b0;
`else
    logic [31:0] want;
    notdone_n = 6;
    st = bus_log.size();
    exp_q.push_back(gcd(9, 6));
    run_job(9, 6, lat, idle, to);
    want = exp_q.pop_front();
    nres = 0; nstat = 0;
    for (int i = st; i < bus_log.size(); i++)
      if (bus_log[i].adr == BASE + 32'hC) nstat++;
    compared++;
    if (to || rsp_err !== 1'b0 || rsp_gcd !== want) begin
      mismatched++;
      $display("FAIL long_poll_rsp: got timeout=%0b err=%b gcd=%0d want err=0 gcd=%0d", to, rsp_err, rsp_gcd, want);
    end
    compared++;
    if (nstat != 7 || nres != 0) begin
      mismatched++;
      $display("FAIL long_poll_count: got %0d status reads want 7", nstat);
    end
    handshake();
    notdone_n = 0;
`endif
  endtask

  task automatic test_reset_mid_job();
    int lat, idle, n;
    bit to, saw_rsp;
    logic [31:0] want;
    cmd_a = 100; cmd_b = 75; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(stb && adr == BASE + 32'h4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 50) begin
      mismatched++;
      $display("FAIL rstmid_reach_wrb: got no WR_B strobe within 50 cycles want one");
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (cyc !== 1'b0 || stb !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_bus_drop: got cyc=%b stb=%b want 0/0", cyc, stb);
    end
    rst = 1'b0;
    saw_rsp = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || cyc) saw_rsp = 1'b1;
    end
    compared++;
    if (saw_rsp || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_quiet: got activity=%0b ready=%b want 0/1", saw_rsp, cmd_ready);
    end
    exp_q.push_back(gcd(7, 5));
    run_job(7, 5, lat, idle, to);
    want = exp_q.pop_front();
    compared++;
    if (to || lat != 5 || rsp_gcd !== want) begin
      mismatched++;
      $display("FAIL rstmid_next_job: got lat=%0d gcd=%0d want lat=5 gcd=%0d", lat, rsp_gcd, want);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat, idle, st;
    bit to, unstable, busy, ready_seen;
    logic [31:0] want, held;
    exp_q.push_back(gcd(12, 8));
    run_job(12, 8, lat, idle, to);
    want = exp_q.pop_front();
    held = rsp_gcd;
    st = bus_log.size();
    unstable = 1'b0; busy = 1'b0; ready_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_gcd !== held || rsp_err !== 1'b0) unstable = 1'b1;
      if (cyc || stb) busy = 1'b1;
      if (cmd_ready) ready_seen = 1'b1;
    end
    compared++;
    if (to || held !== want) begin
      mismatched++;
      $display("FAIL bp_result: got gcd=%0d want %0d", held, want);
    end
    compared++;
    if (unstable) begin
      mismatched++;
      $display("FAIL bp_stable: got response change during stall want stable");
    end
    compared++;
    if (busy || bus_log.size() != st || ready_seen) begin
      mismatched++;
      $display("FAIL bp_idle: got bus=%0b xfers=%0d ready=%0b want 0/0/0", busy, bus_log.size() - st, ready_seen);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat, idle;
    bit to;
    logic [31:0] want;
    exp_q.push_back(gcd(35, 21));
    exp_q.push_back(gcd(17, 5));
    run_job(35, 21, lat, idle, to);
    want = exp_q.pop_front();
    compared++;
    if (to || rsp_gcd !== want) begin
      mismatched++;
      $display("FAIL b2b_first: got gcd=%0d want %0d", rsp_gcd, want);
    end
    handshake();
    run_job(17, 5, lat, idle, to);
    want = exp_q.pop_front();
    compared++;
    if (to || lat != 5 || rsp_gcd !== want) begin
      mismatched++;
      $display("FAIL b2b_second: got lat=%0d gcd=%0d want lat=5 gcd=%0d", lat, rsp_gcd, want);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_polling();
    test_timeout();
    test_reset_mid_job();
    test_backpressure();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion within 40000 cycles want completion");
    $fatal(1, "watchdog");
  end

endmodule
